// File: rtl/ingress_bank_sched.sv
// Ping-pong bank scheduler for the 2x512-word ingress packet RAM.
// Optional reader watchdog: define INGRESS_BANK_WDOG_EN.
module ingress_bank_sched #(
    parameter int CMD_WORDS   = 32,
    parameter int DATA_WORDS  = 256,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       wr_done,
    input  logic       MODE_SET,
    input  logic       rd_done,
    input  logic       clr_err,
    output logic       wr_bank,
    output logic       wr_allow,
    output logic       rd_start,
    output logic       rd_bank,
    output logic       rd_mode,
    output logic [8:0] rd_len,
    output logic [1:0] fill_cnt,
    output logic       overrun,
    output logic       wdog_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2} state_t;

    state_t     state;
    logic [1:0] valid, valid_nxt;
    logic [1:0] mode;
    logic       wr_acc, wr_drop, wd_fire, rd_rel;

    assign wr_acc   = wr_done & ~valid[wr_bank];
    assign wr_drop  = wr_done &  valid[wr_bank];
    assign rd_rel   = (state == BUSY) && (rd_done || wd_fire);
    assign wr_allow = ~valid[wr_bank];
    assign fill_cnt = {1'b0, valid[0]} + {1'b0, valid[1]};

`ifdef INGRESS_BANK_WDOG_EN
    logic [15:0] wdog_cnt;

    // A real rd_done in the expiry cycle wins, so no error is flagged then.
    assign wd_fire = (state == BUSY) && !rd_done && (wdog_cnt == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state == START)
                wdog_cnt <= '0;
            else if (state == BUSY)
                wdog_cnt <= wdog_cnt + 16'd1;
            wdog_err <= wd_fire | (wdog_err & ~clr_err);
        end
    end
`else
    // Watchdog absent; the parameter stays referenced so both builds share one interface.
    assign wd_fire  = 1'b0 & (WDOG_CYCLES > 0);
    assign wdog_err = 1'b0;
`endif

    // A bank being read is always valid, so a write can never land on it.
    always_comb begin
        valid_nxt = valid;
        if (rd_rel) valid_nxt[rd_bank] = 1'b0;
        if (wr_acc) valid_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid   <= 2'b00;
            mode    <= 2'b00;
            wr_bank <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= valid_nxt;
            overrun <= wr_drop | (overrun & ~clr_err);
            if (wr_acc) begin
                mode[wr_bank] <= MODE_SET;
                wr_bank       <= ~wr_bank;
            end
        end
    end

    // Mode and length are captured on entry to START so they accompany the pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            rd_start <= 1'b0;
            rd_bank  <= 1'b0;
            rd_mode  <= 1'b0;
            rd_len   <= '0;
        end else begin
            rd_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid[rd_bank]) begin
                        state    <= START;
                        rd_start <= 1'b1;
                        rd_mode  <= mode[rd_bank];
                        rd_len   <= mode[rd_bank] ? 9'(CMD_WORDS) : 9'(DATA_WORDS);
                    end
                end
                START: state <= BUSY;
                BUSY: begin
                    if (rd_rel) begin
                        rd_bank <= ~rd_bank;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
